// File: rtl/cpu_pkg.sv
// Shared decode-stage definitions: MIPS opcodes, instruction kinds and the
// encoder session state encoding.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_ADDI = 3'd1,
    KIND_LW   = 3'd2,
    KIND_SW   = 3'd3,
    KIND_BEQ  = 3'd4,
    KIND_J    = 3'd5,
    KIND_ILL6 = 3'd6,
    KIND_ILL7 = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: instruction kind plus fields -> 32-bit MIPS word.
// Illegal kinds pack to 32'h0 (sll $0,$0,0, i.e. a nop).
module instr_pack
  import cpu_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word
);

  always_comb begin
    word = 32'h0000_0000;
    case (kind_e'(kind))
      KIND_R:    word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
      KIND_LW:   word = {OP_LW, rs, rt, imm};
      KIND_SW:   word = {OP_SW, rs, rt, imm};
      KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
      KIND_J:    word = {OP_J, target};
      default:   word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Loads encoded instructions into instruction memory, one session per start_i.
// Define INSTR_ENCODER_CHECK_EN to reject kinds 6/7 and flag them on error_o.
module instr_encoder
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int COUNT_W = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  base_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               last_i,
  input  logic               stop_i,
  input  logic [2:0]         kind_i,
  input  logic [4:0]         rs_i,
  input  logic [4:0]         rt_i,
  input  logic [4:0]         rd_i,
  input  logic [5:0]         funct_i,
  input  logic [15:0]        imm_i,
  input  logic [25:0]        target_i,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [31:0]        mem_data_o,
  input  logic               mem_ack_i,
  output logic               done_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               error_o
);

  enc_state_e         state;
  logic               last_q;
  logic [31:0]        word;
  logic [COUNT_W-1:0] count_next;
  logic               kind_bad;

  instr_pack u_pack (
    .kind   (kind_i),
    .rs     (rs_i),
    .rt     (rt_i),
    .rd     (rd_i),
    .funct  (funct_i),
    .imm    (imm_i),
    .target (target_i),
    .word   (word)
  );

  assign count_next = count_o + 1'b1;

`ifdef INSTR_ENCODER_CHECK_EN
  logic error_q;
  assign kind_bad = (kind_i[2:1] == 2'b11);
  assign error_o  = error_q;
`else
  assign kind_bad = 1'b0;
  assign error_o  = 1'b0;
`endif

  // All outputs are registered; each is set on entry to the state that owns it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      ready_o    <= 1'b0;
      mem_we_o   <= 1'b0;
      done_o     <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      count_o    <= '0;
      last_q     <= 1'b0;
`ifdef INSTR_ENCODER_CHECK_EN
      error_q    <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            mem_addr_o <= base_i;
            count_o    <= '0;
`ifdef INSTR_ENCODER_CHECK_EN
            error_q    <= 1'b0;
`endif
            ready_o    <= 1'b1;
            state      <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (valid_i) begin
            if (kind_bad) begin
`ifdef INSTR_ENCODER_CHECK_EN
              error_q <= 1'b1;
`endif
              if (last_i) begin
                ready_o <= 1'b0;
                done_o  <= 1'b1;
                state   <= ST_DONE;
              end
            end else begin
              mem_data_o <= word;
              last_q     <= last_i;
              ready_o    <= 1'b0;
              mem_we_o   <= 1'b1;
              state      <= ST_WRITE;
            end
          end else if (stop_i) begin
            ready_o <= 1'b0;
            done_o  <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_WRITE: begin
          if (mem_ack_i) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= mem_addr_o + ADDR_W'(4);
            count_o    <= count_next;
            if (last_q || (count_next == COUNT_W'(DEPTH))) begin
              done_o <= 1'b1;
              state  <= ST_DONE;
            end else begin
              ready_o <= 1'b1;
              state   <= ST_ACCEPT;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected writes are queued at issue
// and popped by per-instance monitors on each accepted memory write.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] base = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        last = 1'b0, stop = 1'b0;
  logic [2:0]  kind = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;

  logic        a_ready, a_we, a_ack, a_done, a_err;
  logic [31:0] a_addr, a_data;
  logic [8:0]  a_count;
  logic        b_ready, b_we, b_ack, b_done, b_err;
  logic [31:0] b_addr, b_data;
  logic [8:0]  b_count;

  int checks = 0;
  int failures = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];

  logic ack_en = 1'b1;
  int   ack_delay = 0;
  int   wait_cnt;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(32), .DEPTH(256), .COUNT_W(9)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .base_i(base),
    .valid_i(valid_a), .ready_o(a_ready), .last_i(last), .stop_i(stop),
    .kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .funct_i(funct),
    .imm_i(imm), .target_i(target), .mem_we_o(a_we), .mem_addr_o(a_addr),
    .mem_data_o(a_data), .mem_ack_i(a_ack), .done_o(a_done),
    .count_o(a_count), .error_o(a_err));

  instr_encoder #(.ADDR_W(32), .DEPTH(4), .COUNT_W(9)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .base_i(base),
    .valid_i(valid_b), .ready_o(b_ready), .last_i(last), .stop_i(stop),
    .kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .funct_i(funct),
    .imm_i(imm), .target_i(target), .mem_we_o(b_we), .mem_addr_o(b_addr),
    .mem_data_o(b_data), .mem_ack_i(b_ack), .done_o(b_done),
    .count_o(b_count), .error_o(b_err));

  // Memory model: ack after ack_delay wait states (0 = same cycle as the request).
  assign a_ack = a_we && ack_en && (wait_cnt >= ack_delay);
  assign b_ack = b_we;

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (a_we && !a_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(negedge clk) begin
    if (a_we && a_ack) begin
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("FAIL a_write_unexpected addr=%h data=%h", a_addr, a_data);
      end else begin
        logic [63:0] e;
        e = qa.pop_front();
        if ({a_addr, a_data} !== e) begin
          failures++;
          $display("FAIL a_write got addr=%h data=%h exp addr=%h data=%h",
                   a_addr, a_data, e[63:32], e[31:0]);
        end
      end
    end
    if (b_we && b_ack) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL b_write_unexpected addr=%h data=%h", b_addr, b_data);
      end else begin
        logic [63:0] e;
        e = qb.pop_front();
        if ({b_addr, b_data} !== e) begin
          failures++;
          $display("FAIL b_write got addr=%h data=%h exp addr=%h data=%h",
                   b_addr, b_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic start_sess(input logic [31:0] b, input logic use_b);
    @(negedge clk);
    base = b;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [5:0] f, input logic [15:0] im,
                      input logic [25:0] tg, input logic lst, input logic stp);
    int n;
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 100) begin @(negedge clk); n++; end
    chk("send_ready", {63'd0, a_ready}, 64'd1);
    kind = k; rs = s; rt = t; rd = d; funct = f; imm = im; target = tg;
    last = lst; stop = stp; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0; last = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_done(input logic use_b, input int exp_count, input logic exp_err);
    int n;
    n = 0;
    @(negedge clk);
    while (!(use_b ? b_done : a_done) && n < 60) begin @(negedge clk); n++; end
    chk("done_seen", {63'd0, (use_b ? b_done : a_done)}, 64'd1);
    chk("done_count", {55'd0, (use_b ? b_count : a_count)}, 64'(exp_count));
    chk("done_error", {63'd0, (use_b ? b_err : a_err)}, {63'd0, exp_err});
    @(negedge clk);
    chk("done_one_cycle", {63'd0, (use_b ? b_done : a_done)}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_ready", {63'd0, a_ready}, 64'd0);
    chk("rst_we", {63'd0, a_we}, 64'd0);
    chk("rst_done", {63'd0, a_done}, 64'd0);
    chk("rst_err", {63'd0, a_err}, 64'd0);
    chk("rst_addr_data", {a_addr, a_data}, 64'd0);
    chk("rst_count", {55'd0, a_count}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // single addi with last
    start_sess(32'h100, 1'b0);
    qa.push_back({32'h100, 32'h2008000A});
    send(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd10, 26'd0, 1'b1, 1'b0);
    wait_done(1'b0, 1, 1'b0);
    chk("addr_after_session", {32'd0, a_addr}, 64'h104);

    // mixed program from base 0
    start_sess(32'h0, 1'b0);
    qa.push_back({32'h00, 32'h00221820});
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'd0, 1'b0, 1'b0);
    qa.push_back({32'h04, 32'h8C220004});
    send(3'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0, 1'b0);
    qa.push_back({32'h08, 32'hAC220008});
    send(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'd8, 26'd0, 1'b0, 1'b0);
    qa.push_back({32'h0C, 32'h1022FFFF});
    send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0, 1'b0);
    qa.push_back({32'h10, 32'h08000010});
    send(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1, 1'b0);
    wait_done(1'b0, 5, 1'b0);

    // three wait states: request held stable for four cycles
    ack_delay = 3;
    start_sess(32'h300, 1'b0);
    qa.push_back({32'h300, 32'hAC641234});
    send(3'd3, 5'd3, 5'd4, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_we", {63'd0, a_we}, 64'd1);
      chk("stall_addr_data", {a_addr, a_data}, {32'h300, 32'hAC641234});
      chk("stall_ready", {63'd0, a_ready}, 64'd0);
    end
    ack_delay = 0;
    wait_done(1'b0, 1, 1'b0);

    // valid and stop together: valid wins; then stop ends the session
    start_sess(32'h600, 1'b0);
    qa.push_back({32'h600, 32'h20220005});
    send(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0, 1'b1);
    @(negedge clk);
    while (!a_ready) @(negedge clk);
    stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    wait_done(1'b0, 1, 1'b0);

    // reset during a withheld write
    ack_en = 1'b0;
    start_sess(32'h400, 1'b0);
    send(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd10, 26'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("abort_we_before", {63'd0, a_we}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_we_async", {63'd0, a_we}, 64'd0);
    chk("abort_ready", {63'd0, a_ready}, 64'd0);
    @(negedge clk); rst = 1'b0; ack_en = 1'b1;
    start_sess(32'h500, 1'b0);
    chk("restart_count", {55'd0, a_count}, 64'd0);
    chk("restart_addr", {32'd0, a_addr}, 64'h500);
    qa.push_back({32'h500, 32'h2008000A});
    send(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd10, 26'd0, 1'b1, 1'b0);
    wait_done(1'b0, 1, 1'b0);

    // address wrap
    start_sess(32'hFFFFFFFC, 1'b0);
    qa.push_back({32'hFFFFFFFC, 32'h20220005});
    send(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0, 1'b0);
    qa.push_back({32'h0, 32'h0BFFFFFF});
    send(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FFFFFF, 1'b1, 1'b0);
    wait_done(1'b0, 2, 1'b0);

    // illegal kind 7 with last
    start_sess(32'h200, 1'b0);
`ifdef INSTR_ENCODER_CHECK_EN
    send(3'd7, 5'd1, 5'd2, 5'd3, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b1, 1'b0);
    wait_done(1'b0, 0, 1'b1);
    chk("illegal_addr_kept", {32'd0, a_addr}, 64'h200);
`else
    qa.push_back({32'h200, 32'h00000000});
    send(3'd7, 5'd1, 5'd2, 5'd3, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b1, 1'b0);
    wait_done(1'b0, 1, 1'b0);
`endif

    // DEPTH=4 instance: fifth instruction is never accepted
    start_sess(32'h40, 1'b1);
    for (int i = 0; i < 5; i++) begin
      int n;
      n = 0;
      @(negedge clk);
      while (!b_ready && !b_done && n < 20) begin @(negedge clk); n++; end
      if (i == 4) break;
      chk("b_ready", {63'd0, b_ready}, 64'd1);
      qb.push_back({32'h40 + 32'(4 * i), 6'b001000, 5'd0, 5'(i), 16'(i)});
      kind = 3'd1; rs = 5'd0; rt = 5'(i); imm = 16'(i); last = 1'b0; valid_b = 1'b1;
      @(posedge clk); #1; valid_b = 1'b0;
    end
    chk("b_done", {63'd0, b_done}, 64'd1);
    chk("b_count", {55'd0, b_count}, 64'd4);
    valid_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("b_fifth_blocked", {62'd0, b_ready, b_we}, 64'd0);
    end
    valid_b = 1'b0;

    repeat (3) @(negedge clk);
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
